// File: rtl/fp32_frame_fifo.sv
// First-word-fall-through FIFO for 96-bit fp32 operand frames; drops and flags writes when full.
// Optional dropped-frame counter on OVF_CNT_O when FP32_FRAME_FIFO_OVF_CNT_EN is defined.
module fp32_frame_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              WR_VALID_I,
    input  logic [DATA_W-1:0] WR_DATA_I,
    output logic              WR_READY_O,
    output logic              RD_VALID_O,
    output logic [DATA_W-1:0] RD_DATA_O,
    input  logic              RD_READY_I,
    output logic [ADDR_W:0]   COUNT_O,
    output logic              OVF_O
`ifdef FP32_FRAME_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]       OVF_CNT_O
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              wr_ready, rd_valid, wr_fire, rd_fire;

    // Status is decoded from the registered count only, so no input reaches an output combinationally.
    assign wr_ready   = (count_q != FULL_CNT);
    assign rd_valid   = (count_q != '0);
    assign wr_fire    = WR_VALID_I & wr_ready;
    assign rd_fire    = rd_valid & RD_READY_I;

    assign WR_READY_O = wr_ready;
    assign RD_VALID_O = rd_valid;
    assign RD_DATA_O  = mem_q[rd_ptr_q];
    assign COUNT_O    = count_q;
    assign OVF_O      = ovf_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = WR_VALID_I & ~wr_ready;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = WR_DATA_I;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    // The array is cleared on reset so the head reads zero until the first new frame lands.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef FP32_FRAME_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped frames, cleared only by reset.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign OVF_CNT_O = ovf_cnt_q;
`endif

endmodule

// File: doc/fp32_frame_fifo.md
# fp32_frame_fifo

Synchronous first-word-fall-through FIFO that buffers complete 96-bit operand frames (three packed fp32 words) between the UART frame receiver and the downstream consumer (96-bit UART transmitter or fp32 MAC). The receiver cannot be stalled, so this block absorbs bursts while the consumer is busy. Frames arriving when full are dropped and flagged.

## Interface
Parameters:
- DATA_W, 96, frame width in bits.
- DEPTH, 4, number of frame entries; power of two, ≥ 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK_I  input  1  single clock; all logic on rising edge.
- RST_I  input  1  synchronous, active-high reset.
- WR_VALID_I  input  1  upstream frame valid; single-cycle pulse per frame.
- WR_DATA_I  input  DATA_W  upstream frame.
- WR_READY_O  output  1  FIFO can accept a frame this cycle.
- RD_VALID_O  output  1  head frame present on RD_DATA_O.
- RD_DATA_O  output  DATA_W  head frame.
- RD_READY_I  input  1  consumer accepts head frame.
- COUNT_O  output  ADDR_W+1  stored frame count, 0..DEPTH.
- OVF_O  output  1  one-cycle pulse when a frame is dropped.
- OVF_CNT_O  output  16  dropped-frame counter; present only with FP32_FRAME_FIFO_OVF_CNT_EN.

## Operation
- Storage: DEPTH x DATA_W register array, write pointer wr_ptr, read pointer rd_ptr (ADDR_W bits each), count register (ADDR_W+1 bits).
- Write accepted: wr_fire = WR_VALID_I & WR_READY_O. Stores WR_DATA_I at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accepted: rd_fire = RD_VALID_O & RD_READY_I. rd_ptr increments modulo DEPTH.
- count: +1 on wr_fire only, −1 on rd_fire only, unchanged on both or neither.
- WR_READY_O = (count != DEPTH). RD_VALID_O = (count != 0). COUNT_O = count.
- RD_DATA_O = mem[rd_ptr], combinational from the registered array and pointer (first-word fall-through).
- Full: WR_VALID_I while count == DEPTH is dropped even if rd_fire occurs in the same cycle. OVF_O pulses high the next cycle. Array, wr_ptr and count are unaffected by the dropped write.
- Empty: RD_READY_I while count == 0 has no effect. rd_ptr does not move.
- Simultaneous wr_fire and rd_fire with 0 < count < DEPTH: both pointers advance and count holds.
- Pointers wrap from DEPTH−1 to 0 with no gap.
- Reset (any cycle, including mid-burst) clears pointers, count, the whole array and OVF_O. An in-flight write in the reset cycle is discarded.
- Reset values: WR_READY_O=1, RD_VALID_O=0, RD_DATA_O=0, COUNT_O=0, OVF_O=0, OVF_CNT_O=0.

## Timing
- Write-to-read latency is 1 cycle. A frame written at edge N has RD_VALID_O=1 and RD_DATA_O valid after edge N, even when the FIFO was empty.
- Head frame is presented the same cycle rd_ptr advances. A new head is visible immediately after the rd_fire edge.
- WR_READY_O and RD_VALID_O are decoded from registered count only. There is no combinational path from RD_READY_I or WR_VALID_I to any output.
- OVF_O is registered: high exactly one cycle, at the edge after the dropped write.
- Sustained throughput is one frame per cycle in and out while not full or empty.

## Configuration
- FP32_FRAME_FIFO_OVF_CNT_EN defined:
  - OVF_CNT_O port exists.
  - A 16-bit counter increments on every dropped frame and saturates at 16'hFFFF.
  - The counter is cleared only by RST_I.
- Undefined: the port and counter are absent. OVF_O pulse behaviour is identical in both builds.

## Test plan
- Reset, then write frames 96'h1, 96'h2, 96'h3 with RD_READY_I=0:
  - COUNT_O=3 and RD_DATA_O=96'h1.
  - Then RD_READY_I=1 for 3 cycles reads 1, 2, 3 in order, and RD_VALID_O=0 after.
- Fill to DEPTH=4, then write 96'hDEAD with RD_READY_I=1 in the same cycle:
  - The write is dropped and OVF_O pulses once.
  - COUNT_O goes 4→3.
  - Subsequent reads never return 96'hDEAD.
- Continuous write+read every cycle for 10 frames (0xA0..0xA9) starting empty:
  - Output sequence matches input with 1-cycle latency and COUNT_O ≤ 1.
  - Pointers wrap at least twice.
- Write 2 frames, assert RST_I for one cycle together with a third write:
  - COUNT_O=0, RD_VALID_O=0, RD_DATA_O=0, WR_READY_O=1.
  - The next write appears at the head with no stale data.
- With FP32_FRAME_FIFO_OVF_CNT_EN, keep full and drive 70000 consecutive writes: OVF_CNT_O saturates at 16'hFFFF and reset returns it to 0.
- Without the macro, compile and rerun the overflow scenario: OVF_O pulses match the macro build cycle-for-cycle.
